// File: rtl/button_irq_ctrl.sv
// Button debouncer with edge-selectable event capture and an interrupt register set
// (GIE / IER / STATUS / ACK / PENDING / LEVEL / EDGE) driving one level irq line.
module button_irq_ctrl #(
    parameter int   NUM_BTN          = 4,
    parameter int   DEBOUNCE_CYCLES  = 16,
    parameter logic IRQ_ACTIVE_STATE = 1'b1
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [4:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_rvalid,
    output logic               irq
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] SEL_GIE     = 3'd0;
    localparam logic [2:0] SEL_IER     = 3'd1;
    localparam logic [2:0] SEL_STATUS  = 3'd2;
    localparam logic [2:0] SEL_ACK     = 3'd3;
    localparam logic [2:0] SEL_PENDING = 3'd4;
    localparam logic [2:0] SEL_LEVEL   = 3'd5;
    localparam logic [2:0] SEL_EDGE    = 3'd6;

    // Input capture followed by the 2-FF synchronizer; sync_q is the debouncer's view.
    logic [NUM_BTN-1:0] meta_q;
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync_q;
    logic [NUM_BTN-1:0] stable_q;
    logic [NUM_BTN-1:0] stable_d;
    logic [NUM_BTN-1:0] stable_dly_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];

    logic               gie_q;
    logic [NUM_BTN-1:0] ier_q;
    logic [NUM_BTN-1:0] status_q;
    logic [NUM_BTN-1:0] status_d;
    logic [NUM_BTN-1:0] edge_q;
    logic [31:0]        rdata_q;
    logic               rvalid_q;
    logic               irq_q;

    logic [2:0]         sel;
    logic [NUM_BTN-1:0] ack_mask;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] event_w;
    logic [NUM_BTN-1:0] pending;
    logic [31:0]        rd_val;
    logic               unused_bits;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic mismatch;
            logic settle;
            assign mismatch     = sync_q[gi] ^ stable_q[gi];
            assign settle       = mismatch && (cnt_q[gi] == CNT_MAX);
            assign cnt_d[gi]    = (!mismatch || settle) ? '0 : cnt_q[gi] + 1'b1;
            assign stable_d[gi] = settle ? sync_q[gi] : stable_q[gi];
        end
    endgenerate

    assign rise     = stable_q & ~stable_dly_q;
    assign fall     = ~stable_q & stable_dly_q;
    assign event_w  = (rise & edge_q) | (fall & ~edge_q);
    assign sel      = reg_addr[4:2];
    assign ack_mask = (reg_wr && sel == SEL_ACK) ? reg_wdata[NUM_BTN-1:0] : '0;
    // A new event beats an acknowledge of the same bit in the same cycle.
    assign status_d = (status_q & ~ack_mask) | event_w;
    assign pending  = status_q & ier_q;
    assign unused_bits = ^{reg_addr[1:0], reg_wdata};

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_GIE:     rd_val[0]           = gie_q;
            SEL_IER:     rd_val[NUM_BTN-1:0] = ier_q;
            SEL_STATUS:  rd_val[NUM_BTN-1:0] = status_q;
            SEL_PENDING: rd_val[NUM_BTN-1:0] = pending;
            SEL_LEVEL:   rd_val[NUM_BTN-1:0] = stable_q;
            SEL_EDGE:    rd_val[NUM_BTN-1:0] = edge_q;
            default:     rd_val              = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            meta_q       <= '0;
            sync1_q      <= '0;
            sync_q       <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
        end else begin
            meta_q       <= btn_in;
            sync1_q      <= meta_q;
            sync_q       <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            gie_q    <= 1'b0;
            ier_q    <= '0;
            status_q <= '0;
            edge_q   <= '1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= ~IRQ_ACTIVE_STATE;
        end else begin
            if (reg_wr && sel == SEL_GIE)  gie_q  <= reg_wdata[0];
            if (reg_wr && sel == SEL_IER)  ier_q  <= reg_wdata[NUM_BTN-1:0];
            if (reg_wr && sel == SEL_EDGE) edge_q <= reg_wdata[NUM_BTN-1:0];
            status_q <= status_d;
            rvalid_q <= reg_rd;
            if (reg_rd) rdata_q <= rd_val;
            irq_q    <= (gie_q && |pending) ? IRQ_ACTIVE_STATE : ~IRQ_ACTIVE_STATE;
        end
    end

    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Scoreboard bench for button_irq_ctrl: a cycle-level reference model predicts reads and
// irq; a negedge monitor pops predictions whenever the DUT presents read data.
module tb_button_irq_ctrl;

    localparam int N = 4;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        irq;

    always #5 clk = ~clk;

    button_irq_ctrl #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D), .IRQ_ACTIVE_STATE(1'b1)) dut (
        .ACLK(clk), .ARESET(rst), .btn_in(btn), .reg_wr(wr), .reg_rd(rd),
        .reg_addr(addr), .reg_wdata(wdata), .reg_rdata(reg_rdata),
        .reg_rvalid(reg_rvalid), .irq(irq)
    );

    typedef struct { bit chk; logic [4:0] a; logic [31:0] val; } dir_t;

    // Reference model state
    logic        gie_m;
    logic [N-1:0] ier_m, status_m, edge_m, stable_m, rose_m, fell_m;
    logic        irq_m, rvalid_m;
    logic [31:0] rdata_m;
    logic [N-1:0] evt_m, ack_m, st_new_m, stable_new_m, samp_tmp;
    logic [N-1:0] samp_q[$];
    logic [31:0] exp_q[$];
    dir_t        dir_q[$];
    bit          mon_en = 1'b0;
    bit          settled;
    int          checks = 0;
    int          passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a[4:2])
            3'd0: return {31'b0, gie_m};
            3'd1: return {28'b0, ier_m};
            3'd2: return {28'b0, status_m};
            3'd4: return {28'b0, status_m & ier_m};
            3'd5: return {28'b0, stable_m};
            3'd6: return {28'b0, edge_m};
            default: return 32'h0;
        endcase
    endfunction

    // Debounce rule: a level is accepted once the synchronized input (btn delayed by
    // three edges) has disagreed with the accepted level for D consecutive edges.
    always @(posedge clk) begin
        if (rst) begin
            gie_m = 1'b0; ier_m = '0; status_m = '0; edge_m = '1; stable_m = '0;
            rose_m = '0; fell_m = '0; irq_m = 1'b0; rvalid_m = 1'b0; rdata_m = '0;
            exp_q.delete();
            samp_q.delete();
            for (int k = 0; k < D + 3; k++) samp_q.push_back('0);
            mon_en = 1'b1;
        end else begin
            evt_m    = (rose_m & edge_m) | (fell_m & ~edge_m);
            irq_m    = gie_m & (|(status_m & ier_m));
            rvalid_m = rd;
            if (rd) begin
                rdata_m = model_read(addr);
                exp_q.push_back(rdata_m);
            end
            ack_m    = (wr && addr[4:2] == 3'd3) ? wdata[N-1:0] : '0;
            st_new_m = (status_m & ~ack_m) | evt_m;
            if (wr) begin
                case (addr[4:2])
                    3'd0: gie_m  = wdata[0];
                    3'd1: ier_m  = wdata[N-1:0];
                    3'd6: edge_m = wdata[N-1:0];
                    default: ;
                endcase
            end
            samp_q.push_back(btn);
            void'(samp_q.pop_front());
            stable_new_m = stable_m;
            for (int b = 0; b < N; b++) begin
                settled = 1'b1;
                for (int j = 3; j <= D + 2; j++) begin
                    samp_tmp = samp_q[samp_q.size() - 1 - j];
                    if (samp_tmp[b] == stable_m[b]) settled = 1'b0;
                end
                if (settled) stable_new_m[b] = ~stable_m[b];
            end
            rose_m   = stable_new_m & ~stable_m;
            fell_m   = ~stable_new_m & stable_m;
            stable_m = stable_new_m;
            status_m = st_new_m;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            check("irq", {31'b0, irq}, {31'b0, irq_m});
            check("rvalid", {31'b0, reg_rvalid}, {31'b0, rvalid_m});
            if (reg_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", reg_rdata, 32'hxxxx_xxxx);
                end else begin
                    dir_t        dv;
                    logic [31:0] ev;
                    ev = exp_q.pop_front();
                    check("rd_model", reg_rdata, ev);
                    if (dir_q.size() != 0) begin
                        dv = dir_q.pop_front();
                        if (dv.chk) check("rd_const", reg_rdata, dv.val);
                        $display("read @%02h -> %08h (model %08h)", dv.a, reg_rdata, ev);
                    end
                end
            end else begin
                check("rdata_hold", reg_rdata, rdata_m);
            end
        end
    end

    task automatic op(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d,
                      input bit chk, input logic [31:0] e);
        dir_t dv;
        wr = w; rd = r; addr = a; wdata = d;
        if (r) begin
            dv.chk = chk; dv.a = a; dv.val = e;
            dir_q.push_back(dv);
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic wreg(input logic [4:0] a, input logic [31:0] d);
        op(1'b1, 1'b0, a, d, 1'b0, 32'h0);
    endtask

    task automatic rchk(input logic [4:0] a, input logic [31:0] e);
        op(1'b0, 1'b1, a, 32'h0, 1'b1, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dir_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        // Reset defaults
        rchk(5'h00, 0); rchk(5'h04, 0); rchk(5'h08, 0); rchk(5'h10, 0);
        rchk(5'h18, 32'hF); rchk(5'h0C, 0); rchk(5'h1C, 0);

        // Press to irq with exact latency
        wreg(5'h00, 1); wreg(5'h04, 1);
        btn[0] = 1'b1;
        idle(19);
        rchk(5'h08, 0);
        rchk(5'h08, 1);
        rchk(5'h10, 1);
        wreg(5'h0C, 1);
        rchk(5'h10, 0);
        btn[0] = 1'b0;
        idle(25);

        // Glitch rejection then acceptance
        btn[2] = 1'b1; idle(15); btn[2] = 1'b0; idle(25);
        rchk(5'h14, 0); rchk(5'h08, 0);
        btn[2] = 1'b1; idle(16); btn[2] = 1'b0; idle(4);
        rchk(5'h14, 4); rchk(5'h08, 4);
        idle(30);
        wreg(5'h0C, 4);

        // Masking, simultaneous read/write, GIE off
        wreg(5'h04, 0);
        btn[1] = 1'b1; idle(25);
        rchk(5'h08, 2); rchk(5'h10, 0);
        wreg(5'h04, 2); idle(2);
        op(1'b1, 1'b1, 5'h04, 32'h3, 1'b1, 32'h2);
        wreg(5'h00, 0);
        rchk(5'h08, 2);
        btn[1] = 1'b0; idle(25);
        wreg(5'h0C, 2);

        // Release-edge capture and event/ack race
        wreg(5'h18, 0); wreg(5'h00, 1); wreg(5'h04, 8);
        btn[3] = 1'b1; idle(25);
        rchk(5'h08, 0);
        btn[3] = 1'b0; idle(19);
        wreg(5'h0C, 8);
        rchk(5'h08, 8);
        wreg(5'h0C, 8);
        rchk(5'h08, 0);
        wreg(5'h18, 32'hF);

        // Reset mid-debounce with irq asserted
        wreg(5'h04, 3);
        btn[0] = 1'b1; idle(25);
        btn[1] = 1'b1; idle(12);
        do_reset();
        rchk(5'h00, 0); rchk(5'h04, 0); rchk(5'h08, 0); rchk(5'h18, 32'hF); rchk(5'h10, 0);
        idle(13);
        rchk(5'h14, 0);
        rchk(5'h14, 3);
        idle(5);
        wreg(5'h00, 1); wreg(5'h04, 3); idle(3);
        rchk(5'h10, 3);
        btn = '0; idle(25);
        wreg(5'h0C, 32'hF);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int          b;
            logic        w, r;
            logic [4:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 24) == 0) begin
                b = $urandom_range(0, N - 1);
                btn[b] = ~btn[b];
            end
            w = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 3) == 0);
            a = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            d = $urandom;
            op(w, r, a, d, 1'b0, 32'h0);
        end
        idle(3);
        check("rd_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_irq_ctrl.md
# button_irq_ctrl

Debounces up to NUM_BTN asynchronous push-buttons, detects press/release events and sequences them through an interrupt register set of global enable, per-bit enable, status, acknowledge and pending, driving one level `irq` line. It is the control core behind the button-interrupt AXI4-Lite peripheral: the AXI slave wrapper maps its simple register port, and `irq` goes to the PS fabric interrupt input. Register offsets match the existing interrupt map: 0x00 GIE, 0x04 IER, 0x0C ACK, 0x10 PENDING.

## Interface
- NUM_BTN, 4: number of buttons, 1..32
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a new level, ≥2
- IRQ_ACTIVE_STATE, 1: level of `irq` when asserted
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- btn_in  in  NUM_BTN  raw button levels, asynchronous, 1 = pressed
- reg_wr  in  1  write strobe, one-cycle
- reg_rd  in  1  read strobe, one-cycle
- reg_addr  in  5  byte address, bits [1:0] ignored
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid when reg_rvalid
- reg_rvalid  out  1  one-cycle pulse, the cycle after reg_rd
- irq  out  1  interrupt output

## Operation
- Register map, bits above NUM_BTN read 0:
  - 0x00 GIE (RW, bit 0)
  - 0x04 IER (RW)
  - 0x08 STATUS (RO, raw latched events)
  - 0x0C ACK (WO, write-1-to-clear STATUS, reads 0)
  - 0x10 PENDING (RO, STATUS & IER)
  - 0x14 LEVEL (RO, debounced levels)
  - 0x18 EDGE (RW; bit=1 latches press/rising edge, bit=0 latches release/falling edge; reset all 1)
- Unmapped addresses read 0. Writes to RO or unmapped addresses are ignored.
- Per button:
  - 2-FF synchronizer, then a debounce counter of width clog2(DEBOUNCE_CYCLES).
  - Counter clears whenever sync == stable; otherwise it increments.
  - When sync ≠ stable for DEBOUNCE_CYCLES consecutive cycles, stable takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Event: a one-cycle pulse when stable changes in the EDGE-selected direction. It sets its STATUS bit regardless of IER or GIE.
- STATUS bit: set on event, cleared by ACK write of 1. Event and ACK on the same bit in the same cycle: set wins.
- irq is registered as IRQ_ACTIVE_STATE when GIE & |PENDING, else the inverse level.
  - Clearing GIE or IER deasserts irq but keeps STATUS.
  - Re-enabling re-asserts irq if STATUS is still set.
- Simultaneous reg_wr and reg_rd: both execute. The read returns the pre-write value.

## Timing
- Reset values: GIE=0, IER=0, STATUS=0, EDGE=all 1, stable=0, counters=0, sync FFs=0.
- Output reset values: reg_rdata=0, reg_rvalid=0, irq=~IRQ_ACTIVE_STATE.
- ARESET mid-debounce or with pending irq: everything returns to reset values next edge. A held button is re-accepted after debounce.
- Press latency, with btn_in first sampled high at edge 0:
  - sync high after edge 2
  - stable high after edge 2+DEBOUNCE_CYCLES
  - STATUS set after edge 3+DEBOUNCE_CYCLES
  - irq asserted after edge 4+DEBOUNCE_CYCLES
- Register write takes effect at the strobe edge; irq reflects it one cycle later.
- ACK at edge N: STATUS clear after N, irq deasserted after N+1.
- Read: reg_rdata and reg_rvalid at edge after reg_rd. reg_rdata holds until the next read.
- Multiple buttons settling in the same cycle set all their bits in the same cycle.

## Test plan
Parameters: NUM_BTN=4, DEBOUNCE_CYCLES=16.
- **Reset defaults:** after reset, read 0x00/0x04/0x08/0x10/0x18 -> 0,0,0,0,0x0000000F; irq=0.
- **Press to irq:** GIE=1, IER=0x1; btn_in[0]=1 held → STATUS=0x1 exactly 19 cycles after first sample, irq=1 at 20. PENDING reads 0x1. ACK 0x1 → PENDING 0x0, irq=0 one cycle after ACK.
- **Glitch rejection:** btn_in[2] high 15 cycles then low → LEVEL stays 0, STATUS 0. High 16+ cycles → LEVEL=0x4, STATUS=0x4.
- **Masking:** IER=0, press btn1 → STATUS=0x2, PENDING=0, irq=0. Write IER=0x2 → irq=1 two cycles later. GIE=0 → irq=0, STATUS still 0x2.
- **Release edge and ack race:** EDGE=0x0, press then release btn3 → STATUS=0x8 only after release. Event coinciding with ACK 0x8 → STATUS remains 0x8.
- **Reset mid-operation:** ARESET during debounce count 10 with irq asserted → irq=0 next cycle, all registers at defaults. A still-held button gives LEVEL set after 2+16 cycles, but no irq until GIE and IER are re-written.
